vga_fb_arbiter: RTL

- Shares one single-port synchronous framebuffer RAM between two requesters.
- Display requester: scanout pixel fetch. Must meet line deadlines, so it has priority during active video.
- Host requester: CPU/draw engine reads and writes. Gets priority during blanking and has a bounded-wait starvation guard during active video.
- Sits between the VGA timing/pixel pipeline and the framebuffer RAM.

---
 rtl/vga_fb_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter
// Shares one single-port synchronous framebuffer RAM between the scanout
// fetch (display) and the CPU/draw-engine port (host).
//
// Ports
//   clk, rst                 pixel clock, asynchronous active-high reset
//   blank                    1 while the timing generator is in h/v blanking
//   disp_req/addr            display read request
//   disp_gnt                 display accepted this cycle (combinational)
//   disp_rvalid/rdata        display read return, two cycles after grant
//   host_req/we/addr/wdata   host read or write request
//   host_gnt                 host accepted this cycle (combinational)
//   host_rvalid/rdata        host read return, two cycles after grant
//   mem_en/we/addr/wdata     registered RAM command, one cycle after grant
//   mem_rdata                RAM read data, one cycle after a read command
//
// Priority: host first while blanking or when the host has been denied
// HOST_MAX_WAIT consecutive cycles in active video; display first otherwise.
module vga_fb_arbiter #(
    parameter int AW            = 17,
    parameter int DW            = 12,
    parameter int HOST_MAX_WAIT = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          blank,
    input  logic          disp_req,
    input  logic [AW-1:0] disp_addr,
    output logic          disp_gnt,
    output logic          disp_rvalid,
    output logic [DW-1:0] disp_rdata,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_gnt,
    output logic          host_rvalid,
    output logic [DW-1:0] host_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    // A zero-width counter is not legal, so the disabled guard keeps one bit.
    localparam int WCW = (HOST_MAX_WAIT > 0) ? $clog2(HOST_MAX_WAIT + 1) : 1;
    localparam logic [WCW-1:0] WAIT_MAX = WCW'(HOST_MAX_WAIT);

    // Tag carried alongside each access until its data returns.
    typedef struct packed {
        logic valid;
        logic host;
        logic read;
    } tag_t;

    logic [WCW-1:0] wait_cnt_r;
    logic           force_s;
    logic           host_first_s;
    logic           disp_gnt_s;
    logic           host_gnt_s;
    logic           mem_en_r;
    logic           mem_we_r;
    logic [AW-1:0]  mem_addr_r;
    logic [DW-1:0]  mem_wdata_r;
    tag_t           tag_r;
    logic           disp_rvalid_r;
    logic           host_rvalid_r;

    // Grant selection from the current-cycle requests; nothing is granted in reset.
    always_comb begin
        force_s      = (HOST_MAX_WAIT != 0) && (wait_cnt_r >= WAIT_MAX);
        host_first_s = blank | force_s;
        disp_gnt_s   = 1'b0;
        host_gnt_s   = 1'b0;
        if (rst) begin
            disp_gnt_s = 1'b0;
            host_gnt_s = 1'b0;
        end else if (host_first_s) begin
            host_gnt_s = host_req;
            disp_gnt_s = disp_req & ~host_req;
        end else begin
            disp_gnt_s = disp_req;
            host_gnt_s = host_req & ~disp_req;
        end
    end

    // Host starvation counter: counts consecutive denied host cycles, saturating.
    // A granted host clears it, so a forced grant only lasts one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_r <= '0;
        end else if (host_gnt_s || !host_req) begin
            wait_cnt_r <= '0;
        end else if (wait_cnt_r < WAIT_MAX) begin
            wait_cnt_r <= wait_cnt_r + WCW'(1);
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // Issue stage: register the granted command toward the RAM.
    // Address and write data hold their last values when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_en_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
        end else begin
            mem_en_r <= disp_gnt_s | host_gnt_s;
            mem_we_r <= host_gnt_s & host_we;
            if (host_gnt_s) begin
                mem_addr_r  <= host_addr;
                mem_wdata_r <= host_wdata;
            end else if (disp_gnt_s) begin
                mem_addr_r  <= disp_addr;
                mem_wdata_r <= mem_wdata_r;
            end else begin
                mem_addr_r  <= mem_addr_r;
                mem_wdata_r <= mem_wdata_r;
            end
        end
    end

    // Tag pipeline: stage one travels with the issued command, stage two is
    // the per-owner rvalid aligned with the RAM read data. Writes never return.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_r         <= '0;
            disp_rvalid_r <= 1'b0;
            host_rvalid_r <= 1'b0;
        end else begin
            tag_r.valid   <= disp_gnt_s | host_gnt_s;
            tag_r.host    <= host_gnt_s;
            tag_r.read    <= ~(host_gnt_s & host_we);
            disp_rvalid_r <= tag_r.valid & tag_r.read & ~tag_r.host;
            host_rvalid_r <= tag_r.valid & tag_r.read & tag_r.host;
        end
    end

    assign disp_gnt    = disp_gnt_s;
    assign host_gnt    = host_gnt_s;
    assign mem_en      = mem_en_r;
    assign mem_we      = mem_we_r;
    assign mem_addr    = mem_addr_r;
    assign mem_wdata   = mem_wdata_r;
    assign disp_rvalid = disp_rvalid_r;
    assign host_rvalid = host_rvalid_r;
    // Read data is a pass-through; only the owner's rvalid qualifies it.
    assign disp_rdata  = mem_rdata;
    assign host_rdata  = mem_rdata;

endmodule
